// File: rtl/alu_pkg.sv
// Shared definitions for the round-robin ALU scheduler: select codes,
// FSM state encoding and select classification helpers.
package alu_pkg;

    localparam logic [3:0] OP_PASS_A = 4'd0;
    localparam logic [3:0] OP_PASS_B = 4'd1;
    localparam logic [3:0] OP_ADD    = 4'd2;
    localparam logic [3:0] OP_SUB    = 4'd3;
    localparam logic [3:0] OP_DIV    = 4'd4;
    localparam logic [3:0] OP_MOD    = 4'd5;
    localparam logic [3:0] OP_SHL    = 4'd6;
    localparam logic [3:0] OP_SHR    = 4'd7;
    localparam logic [3:0] OP_GT     = 4'd8;
    localparam logic [3:0] OP_EQ     = 4'd9;
    localparam logic [3:0] OP_MUL    = 4'd10;
    localparam logic [3:0] OP_AND    = 4'd11;
    localparam logic [3:0] OP_OR     = 4'd12;
    localparam logic [3:0] OP_XOR    = 4'd13;
    localparam logic [3:0] OP_CAT    = 4'd14;
    localparam logic [3:0] OP_AVG    = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic logic is_divide(input logic [3:0] sel);
        return (sel == OP_DIV) || (sel == OP_MOD);
    endfunction

    function automatic logic is_multicycle(input logic [3:0] sel);
        return is_divide(sel) || (sel == OP_MUL);
    endfunction

endpackage

// File: rtl/Sabals_ALU.sv
// Combinational 8-bit ALU producing a zero-extended 16-bit result.
module Sabals_ALU
    import alu_pkg::*;
(
    input  logic [3:0]  i_sel,
    input  logic [7:0]  i_a,
    input  logic [7:0]  i_b,
    output logic [15:0] o_result
);

    logic [8:0] w_sum9;

    assign w_sum9 = {1'b0, i_a} + {1'b0, i_b};

    always_comb begin
        o_result = '0;
        case (i_sel)
            OP_PASS_A: o_result = {8'h00, i_a};
            OP_PASS_B: o_result = {8'h00, i_b};
            OP_ADD:    o_result = {7'h00, w_sum9};
            OP_SUB:    o_result = {8'h00, i_a} - {8'h00, i_b};
            // Zero divisor yields 0 here; the scheduler flags the error itself.
            OP_DIV:    o_result = (i_b == 8'h00) ? '0 : {8'h00, i_a / i_b};
            OP_MOD:    o_result = (i_b == 8'h00) ? '0 : {8'h00, i_a % i_b};
            OP_SHL:    o_result = {7'h00, i_a, 1'b0};
            OP_SHR:    o_result = {9'h000, i_a[7:1]};
            OP_GT:     o_result = (i_a > i_b) ? '1 : '0;
            OP_EQ:     o_result = (i_a == i_b) ? '1 : '0;
            OP_MUL:    o_result = {8'h00, i_a} * {8'h00, i_b};
            OP_AND:    o_result = {8'h00, i_a & i_b};
            OP_OR:     o_result = {8'h00, i_a | i_b};
            OP_XOR:    o_result = {8'h00, i_a ^ i_b};
            OP_CAT:    o_result = {i_a, i_b};
            OP_AVG:    o_result = {8'h00, w_sum9[8:1]};
            default:   o_result = '0;
        endcase
    end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Two-requester round-robin front end sharing one ALU; one operation in
// flight, multi-cycle selects held in EXEC for DIV_LAT cycles.
module alu_rr_scheduler
    import alu_pkg::*;
#(
    parameter int unsigned DIV_LAT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [3:0]  req0_sel,
    input  logic [7:0]  req0_a,
    input  logic [7:0]  req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [3:0]  req1_sel,
    input  logic [7:0]  req1_a,
    input  logic [7:0]  req1_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [15:0] rsp_data,
    output logic        rsp_err
);

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_last_grant;
    logic [3:0]  r_sel;
    logic [7:0]  r_a;
    logic [7:0]  r_b;
    logic        r_id;
    logic [15:0] r_rsp_data;
    logic        r_rsp_id;
    logic        r_rsp_err;

    logic        w_idle;
    logic        w_any_valid;
    logic        w_grant;
    logic        w_accept;
    logic [3:0]  w_sel;
    logic [7:0]  w_a;
    logic [7:0]  w_b;
    logic [15:0] w_alu;
    logic        w_div_zero;

    assign w_idle      = (r_state == ST_IDLE);
    assign w_any_valid = req0_valid | req1_valid;
    // Contention goes to the requester not granted last; otherwise the lone valid one.
    assign w_grant     = (req0_valid & req1_valid) ? ~r_last_grant : req1_valid;
    assign w_accept    = w_idle & w_any_valid;

    assign req0_ready  = rst_n & w_idle & w_any_valid & ~w_grant;
    assign req1_ready  = rst_n & w_idle & w_any_valid &  w_grant;

    assign w_sel = w_grant ? req1_sel : req0_sel;
    assign w_a   = w_grant ? req1_a   : req0_a;
    assign w_b   = w_grant ? req1_b   : req0_b;

    Sabals_ALU u_alu (
        .i_sel    (r_sel),
        .i_a      (r_a),
        .i_b      (r_b),
        .o_result (w_alu)
    );

    assign w_div_zero = is_divide(r_sel) & (r_b == 8'h00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_last_grant <= 1'b1;
            r_sel        <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_id         <= 1'b0;
            r_rsp_data   <= '0;
            r_rsp_id     <= 1'b0;
            r_rsp_err    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_sel        <= w_sel;
                        r_a          <= w_a;
                        r_b          <= w_b;
                        r_id         <= w_grant;
                        r_last_grant <= w_grant;
                        r_cnt        <= is_multicycle(w_sel) ? 4'(DIV_LAT - 1) : '0;
                        r_state      <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (r_cnt == '0) begin
                        r_rsp_data <= w_div_zero ? '0 : w_alu;
                        r_rsp_err  <= w_div_zero;
                        r_rsp_id   <= r_id;
                        r_state    <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign rsp_valid = (r_state == ST_RESP);
    assign rsp_data  = r_rsp_data;
    assign rsp_id    = r_rsp_id;
    assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Scoreboard bench for alu_rr_scheduler: directed operations push expected
// responses; an independent monitor checks latency, content and stability.
module tb_alu_rr_scheduler;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req0_ready;
    logic [3:0]  req0_sel;
    logic [7:0]  req0_a, req0_b;
    logic        req1_valid, req1_ready;
    logic [3:0]  req1_sel;
    logic [7:0]  req1_a, req1_b;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [15:0] rsp_data;

    alu_rr_scheduler #(.DIV_LAT(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_sel   (req0_sel),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_sel   (req1_sel),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          id;
        logic [15:0] data;
        bit          err;
        int          lat;
        int          acc;
    } exp_t;

    typedef struct {
        bit          port;
        logic [3:0]  sel;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] data;
        bit          err;
        int          lat;
    } vec_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    bit   last_model = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: latency at rise, content at handshake, stability under backpressure.
    initial begin : monitor
        bit          prev_valid;
        bit          hold;
        logic [15:0] h_data;
        logic        h_id, h_err;
        exp_t        e;
        prev_valid = 0;
        hold = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_valid = 0;
                hold = 0;
            end else begin
                if (hold && rsp_valid) begin
                    check("hold_data", rsp_data, h_data);
                    check("hold_id", rsp_id, h_id);
                    check("hold_err", rsp_err, h_err);
                end
                if (rsp_valid && !prev_valid) begin
                    if (sb.size() == 0) check("unexpected_rsp", 1, 0);
                    else check("latency", cyc, sb[0].acc + sb[0].lat);
                end
                if (rsp_valid && rsp_ready) begin
                    if (sb.size() == 0) begin
                        check("unexpected_pop", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        check("rsp_id", rsp_id, e.id);
                        check("rsp_data", rsp_data, e.data);
                        check("rsp_err", rsp_err, e.err);
                    end
                    hold = 0;
                end else if (rsp_valid) begin
                    hold = 1;
                    h_data = rsp_data;
                    h_id = rsp_id;
                    h_err = rsp_err;
                end else begin
                    hold = 0;
                end
                prev_valid = rsp_valid;
            end
        end
    end

    task automatic drive(input bit port, input bit v, input logic [3:0] sel,
                         input logic [7:0] a, input logic [7:0] b);
        if (port) begin
            req1_valid = v; req1_sel = sel; req1_a = a; req1_b = b;
        end else begin
            req0_valid = v; req0_sel = sel; req0_a = a; req0_b = b;
        end
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic issue(input bit port, input logic [3:0] sel, input logic [7:0] a,
                         input logic [7:0] b, input logic [15:0] data, input bit err,
                         input int lat, input bit expect_rsp, output int acc);
        bit   got;
        exp_t e;
        got = 0;
        acc = -1;
        drive(port, 1'b1, sel, a, b);
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (port ? req1_ready : req0_ready) begin
                got = 1;
                acc = cyc + 1;
                check("other_ready", port ? req0_ready : req1_ready, 0);
                last_model = port;
                if (expect_rsp) begin
                    e.id = port; e.data = data; e.err = err; e.lat = lat; e.acc = acc;
                    sb.push_back(e);
                end
            end
        end
        if (!got) check("accept_timeout", 0, 1);
        @(posedge clk); #1;
        drive(port, 1'b0, 4'd0, 8'd0, 8'd0);
    endtask

    task automatic wait_drain();
        bit done;
        done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(posedge clk); #1;
            if (sb.size() == 0 && !rsp_valid) done = 1;
        end
        if (!done) check("drain_timeout", 0, 1);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        last_model = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    vec_t vecs[19] = '{
        '{1'b0, 4'd2,  8'd200, 8'd100, 16'h012C, 1'b0, 1},
        '{1'b1, 4'd10, 8'd255, 8'd255, 16'hFE01, 1'b0, 4},
        '{1'b0, 4'd4,  8'd17,  8'd0,   16'h0000, 1'b1, 4},
        '{1'b0, 4'd5,  8'd17,  8'd5,   16'h0002, 1'b0, 4},
        '{1'b1, 4'd0,  8'h12,  8'h34,  16'h0012, 1'b0, 1},
        '{1'b0, 4'd1,  8'h12,  8'h34,  16'h0034, 1'b0, 1},
        '{1'b1, 4'd3,  8'd5,   8'd7,   16'hFFFE, 1'b0, 1},
        '{1'b0, 4'd6,  8'h81,  8'h00,  16'h0102, 1'b0, 1},
        '{1'b1, 4'd7,  8'h81,  8'h00,  16'h0040, 1'b0, 1},
        '{1'b0, 4'd8,  8'd9,   8'd3,   16'hFFFF, 1'b0, 1},
        '{1'b1, 4'd8,  8'd3,   8'd9,   16'h0000, 1'b0, 1},
        '{1'b0, 4'd9,  8'd7,   8'd7,   16'hFFFF, 1'b0, 1},
        '{1'b1, 4'd11, 8'hF0,  8'h3C,  16'h0030, 1'b0, 1},
        '{1'b0, 4'd12, 8'hF0,  8'h3C,  16'h00FC, 1'b0, 1},
        '{1'b1, 4'd14, 8'h12,  8'h34,  16'h1234, 1'b0, 1},
        '{1'b0, 4'd15, 8'hFF,  8'hFF,  16'h00FF, 1'b0, 1},
        '{1'b1, 4'd15, 8'hFF,  8'h01,  16'h0080, 1'b0, 1},
        '{1'b1, 4'd4,  8'd200, 8'd7,   16'h001C, 1'b0, 4},
        '{1'b0, 4'd5,  8'd9,   8'd0,   16'h0000, 1'b1, 4}
    };

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int  acc;
        int  r0;
        bit  g;
        bit  got;
        exp_t e;

        rst_n = 1'b0;
        rsp_ready = 1'b1;
        drive(1'b0, 1'b1, 4'd2, 8'd1, 8'd1);
        drive(1'b1, 1'b1, 4'd2, 8'd1, 8'd1);
        @(negedge clk);
        check("rst_req0_ready", req0_ready, 0);
        check("rst_req1_ready", req1_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 16'h0000);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_rsp_err", rsp_err, 0);
        drive(1'b0, 1'b0, 4'd0, 8'd0, 8'd0);
        drive(1'b1, 1'b0, 4'd0, 8'd0, 8'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            issue(vecs[i].port, vecs[i].sel, vecs[i].a, vecs[i].b,
                  vecs[i].data, vecs[i].err, vecs[i].lat, 1'b1, acc);
            wait_drain();
        end

        // Contention after reset: grants must alternate starting with requester 0.
        do_reset();
        drive(1'b0, 1'b1, 4'd13, 8'hF0, 8'h0F);
        drive(1'b1, 1'b1, 4'd13, 8'hAA, 8'hFF);
        for (int k = 0; k < 4; k++) begin
            g = ~last_model;
            got = 0;
            for (int i = 0; i < 40 && !got; i++) begin
                @(negedge clk);
                if (req0_ready || req1_ready) begin
                    got = 1;
                    check("rr_grant", {req1_ready, req0_ready}, g ? 2'b10 : 2'b01);
                    check("rr_order", g, (k % 2 == 0) ? 0 : 1);
                    e.id = g;
                    e.data = g ? 16'h0055 : 16'h00FF;
                    e.err = 0;
                    e.lat = 1;
                    e.acc = cyc + 1;
                    sb.push_back(e);
                    last_model = g;
                end
            end
            if (!got) check("rr_timeout", 0, 1);
        end
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 4'd0, 8'd0, 8'd0);
        drive(1'b1, 1'b0, 4'd0, 8'd0, 8'd0);
        wait_drain();

        // Backpressure: result held, req1 locked out, then accepted right after release.
        rsp_ready = 1'b0;
        issue(1'b0, 4'd2, 8'd1, 8'd2, 16'h0003, 1'b0, 1, 1'b1, acc);
        drive(1'b1, 1'b1, 4'd9, 8'd5, 8'd5);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_req1_ready", req1_ready, 0);
        end
        @(posedge clk); #1;
        r0 = cyc;
        rsp_ready = 1'b1;
        issue(1'b1, 4'd9, 8'd5, 8'd5, 16'hFFFF, 1'b0, 1, 1'b1, acc);
        check("bp_accept_edge", acc, r0 + 2);
        wait_drain();

        // Reset mid-EXEC of a multiply: no response for it, next op normal.
        issue(1'b0, 4'd10, 8'd3, 8'd4, 16'h000C, 1'b0, 4, 1'b0, acc);
        @(posedge clk); #1;
        rst_n = 1'b0;
        last_model = 1'b1;
        @(negedge clk);
        check("rst_exec_valid", rsp_valid, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("dropped_no_rsp", rsp_valid, 0);
        end
        @(posedge clk); #1;
        issue(1'b1, 4'd2, 8'd1, 8'd1, 16'h0002, 1'b0, 1, 1'b1, acc);
        wait_drain();

        check("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
